// File: rtl/id_ex_operand_stage_if.sv
// id_ex_operand_stage_if
// Groups the decode-slot, forwarding and control signals of the ID/EX operand stage.
//   slave  : view used by the stage (decode/forward/control in, registered ALU side out)
//   master : view used by the surrounding pipeline (drives inputs, observes outputs)
// Parameters: DW datapath width, RW register index width.
interface id_ex_operand_stage_if #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
);
    // Decode slot
    logic          id_valid_i;
    logic [RW-1:0] id_rs_i;
    logic [RW-1:0] id_rt_i;
    logic [DW-1:0] id_rs_data_i;
    logic [DW-1:0] id_rt_data_i;
    logic [DW-1:0] id_imm_i;
    logic          id_alu_src_i;
    logic [3:0]    id_alu_ctrl_i;
    logic [RW-1:0] id_rd_i;
    logic          id_wb_en_i;
    logic          id_mem_read_i;
    // Forwarding sources
    logic [DW-1:0] ex_result_i;
    logic          wb_en_i;
    logic [RW-1:0] wb_rd_i;
    logic [DW-1:0] wb_data_i;
    // Pipeline control
    logic          hold_i;
    logic          flush_i;
    logic          stall_o;
    // Registered stage outputs
    logic          valid_o;
    logic [DW-1:0] src1_o;
    logic [DW-1:0] src2_o;
    logic [3:0]    ctrl_o;
    logic [DW-1:0] store_data_o;
    logic [RW-1:0] rd_o;
    logic          wb_en_o;
    logic          mem_read_o;

    modport slave (
        input  id_valid_i, id_rs_i, id_rt_i, id_rs_data_i, id_rt_data_i, id_imm_i,
        input  id_alu_src_i, id_alu_ctrl_i, id_rd_i, id_wb_en_i, id_mem_read_i,
        input  ex_result_i, wb_en_i, wb_rd_i, wb_data_i, hold_i, flush_i,
        output stall_o, valid_o, src1_o, src2_o, ctrl_o, store_data_o, rd_o,
        output wb_en_o, mem_read_o
    );

    modport master (
        output id_valid_i, id_rs_i, id_rt_i, id_rs_data_i, id_rt_data_i, id_imm_i,
        output id_alu_src_i, id_alu_ctrl_i, id_rd_i, id_wb_en_i, id_mem_read_i,
        output ex_result_i, wb_en_i, wb_rd_i, wb_data_i, hold_i, flush_i,
        input  stall_o, valid_o, src1_o, src2_o, ctrl_o, store_data_o, rd_o,
        input  wb_en_o, mem_read_o
    );
endinterface

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
// ID/EX pipeline register feeding the ALU. Forwards rs/rt from EX (the instruction held
// here) and MEM/WB, selects src2 between forwarded rt and the immediate, and detects
// load-use hazards (stall decode, insert one bubble).
// Ports:
//   clk_i : clock, rising edge
//   rst_i : synchronous active-high reset, clears every output register
//   bus   : id_ex_operand_stage_if.slave, decode slot, forwarding sources, hold/flush,
//           combinational stall_o and the registered ALU-side outputs
module id_ex_operand_stage #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input logic                  clk_i,
    input logic                  rst_i,
    id_ex_operand_stage_if.slave bus
);

    logic          valid_q;
    logic          wb_en_q;
    logic          mem_read_q;
    logic [3:0]    ctrl_q;
    logic [RW-1:0] rd_q;
    logic [DW-1:0] src1_q;
    logic [DW-1:0] src2_q;
    logic [DW-1:0] store_data_q;

    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;
    logic          ex_fwd_ok;
    logic          load_use;

    // A load held here has no result yet, so it never forwards from EX.
    assign ex_fwd_ok = valid_q & wb_en_q & ~mem_read_q;

    always_comb begin
        fwd_rs = bus.id_rs_data_i;
        if (bus.id_rs_i != '0) begin
            if (ex_fwd_ok && (rd_q == bus.id_rs_i)) begin
                fwd_rs = bus.ex_result_i;
            end else if (bus.wb_en_i && (bus.wb_rd_i == bus.id_rs_i)) begin
                fwd_rs = bus.wb_data_i;
            end
        end
    end

    always_comb begin
        fwd_rt = bus.id_rt_data_i;
        if (bus.id_rt_i != '0) begin
            if (ex_fwd_ok && (rd_q == bus.id_rt_i)) begin
                fwd_rt = bus.ex_result_i;
            end else if (bus.wb_en_i && (bus.wb_rd_i == bus.id_rt_i)) begin
                fwd_rt = bus.wb_data_i;
            end
        end
    end

    // rt only matters for the hazard when it feeds the ALU (immediate forms ignore it).
    assign load_use = valid_q & mem_read_q & (rd_q != '0) & bus.id_valid_i &
                      ((rd_q == bus.id_rs_i) | ((rd_q == bus.id_rt_i) & ~bus.id_alu_src_i));

    // Reset and flush both squash the hazard bubble's stall; hold always stalls.
    assign bus.stall_o = bus.hold_i | (~rst_i & ~bus.flush_i & load_use);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q      <= 1'b0;
            wb_en_q      <= 1'b0;
            mem_read_q   <= 1'b0;
            ctrl_q       <= '0;
            rd_q         <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            store_data_q <= '0;
        end else if (!bus.hold_i) begin
            if (bus.flush_i || load_use) begin
                // Bubble: only control is cleared, data registers are don't-care.
                valid_q    <= 1'b0;
                wb_en_q    <= 1'b0;
                mem_read_q <= 1'b0;
                ctrl_q     <= '0;
                rd_q       <= '0;
            end else begin
                valid_q      <= bus.id_valid_i;
                wb_en_q      <= bus.id_valid_i & bus.id_wb_en_i;
                mem_read_q   <= bus.id_valid_i & bus.id_mem_read_i;
                ctrl_q       <= bus.id_alu_ctrl_i;
                rd_q         <= bus.id_rd_i;
                src1_q       <= fwd_rs;
                src2_q       <= bus.id_alu_src_i ? bus.id_imm_i : fwd_rt;
                store_data_q <= fwd_rt;
            end
        end
    end

    assign bus.valid_o      = valid_q;
    assign bus.wb_en_o      = wb_en_q;
    assign bus.mem_read_o   = mem_read_q;
    assign bus.ctrl_o       = ctrl_q;
    assign bus.rd_o         = rd_q;
    assign bus.src1_o       = src1_q;
    assign bus.src2_o       = src2_q;
    assign bus.store_data_o = store_data_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage
// Directed vector table for forwarding, r0 guard, load-use and immediate select, a
// hand-written hold/flush sequence, then randomized traffic against a reference model
// of the last instruction issued into the stage.
module tb_id_ex_operand_stage;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    id_ex_operand_stage_if #(.DW(DW), .RW(RW)) bus ();

    id_ex_operand_stage #(.DW(DW), .RW(RW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        bit          rst;
        bit          v;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] rsd;
        logic [31:0] rtd;
        logic [31:0] imm;
        bit          asrc;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        bit          we;
        bit          mr;
        logic [31:0] exr;
        bit          wben;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        bit          hold;
        bit          flush;
    } in_t;

    // Stage contents; dk = data registers have a defined value.
    typedef struct {
        bit          v;
        bit          we;
        bit          mr;
        logic [3:0]  ctrl;
        logic [4:0]  rd;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [31:0] sd;
        bit          dk;
    } st_t;

    typedef struct {
        in_t x;
        bit  stall;
        st_t e;
    } vec_t;

    int unsigned npass = 0;
    int unsigned ntot  = 0;
    st_t         m;      // reference model state
    bit          m_stall;
    logic        stall_act;
    st_t         obs;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: actual %0h, required %0h", name, act, exp);
    endtask

    function automatic in_t ins(input bit v, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [31:0] rsd, input logic [31:0] rtd,
                                input logic [31:0] imm, input bit asrc, input logic [3:0] ctrl,
                                input logic [4:0] rd, input bit we, input bit mr);
        in_t x;
        x = '{default: '0};
        x.v = v; x.rs = rs; x.rt = rt; x.rsd = rsd; x.rtd = rtd; x.imm = imm;
        x.asrc = asrc; x.ctrl = ctrl; x.rd = rd; x.we = we; x.mr = mr;
        return x;
    endfunction

    function automatic vec_t vec(input in_t x, input bit stall, input bit v, input bit we,
                                 input bit mr, input logic [3:0] ctrl, input logic [4:0] rd,
                                 input logic [31:0] s1, input logic [31:0] s2,
                                 input logic [31:0] sd, input bit dk);
        vec_t t;
        t.x = x; t.stall = stall;
        t.e.v = v; t.e.we = we; t.e.mr = mr; t.e.ctrl = ctrl; t.e.rd = rd;
        t.e.s1 = s1; t.e.s2 = s2; t.e.sd = sd; t.e.dk = dk;
        return t;
    endfunction

    function automatic in_t rand_in();
        in_t x;
        x.rst = ($urandom_range(31) == 0);
        x.v = ($urandom_range(7) != 0);
        x.rs = 5'($urandom_range(7));
        x.rt = 5'($urandom_range(7));
        x.rsd = $urandom; x.rtd = $urandom; x.imm = $urandom;
        x.asrc = 1'($urandom_range(1));
        x.ctrl = 4'($urandom_range(15));
        x.rd = 5'($urandom_range(7));
        x.we = ($urandom_range(3) != 0);
        x.mr = ($urandom_range(3) == 0);
        x.exr = $urandom;
        x.wben = 1'($urandom_range(1));
        x.wbrd = 5'($urandom_range(7));
        x.wbd = $urandom;
        x.hold = ($urandom_range(7) == 0);
        x.flush = ($urandom_range(7) == 0);
        return x;
    endfunction

    // Value an instruction reading register s sees: newest in-flight producer wins,
    // a load still in EX has nothing to give, r0 is always the file value.
    function automatic logic [31:0] operand(input st_t st, input in_t x, input logic [4:0] s,
                                            input logic [31:0] rf);
        if (s == 5'd0) return rf;
        if (st.v && st.we && !st.mr && st.rd == s) return x.exr;
        if (x.wben && x.wbrd == s) return x.wbd;
        return rf;
    endfunction

    task automatic model_step(input in_t x);
        bit          lu;
        logic [31:0] rt_val;
        lu = m.v && m.mr && m.rd != 0 && x.v &&
             (m.rd == x.rs || (m.rd == x.rt && !x.asrc));
        m_stall = x.hold || (!x.rst && !x.flush && lu);
        if (x.rst) begin
            m = '{default: '0};
            m.dk = 1'b1;
        end else if (x.hold) begin
            m = m;
        end else if (x.flush || lu) begin
            m.v = 0; m.we = 0; m.mr = 0; m.ctrl = '0; m.rd = '0; m.dk = 0;
        end else begin
            rt_val = operand(m, x, x.rt, x.rtd);
            m.s1 = operand(m, x, x.rs, x.rsd);
            m.s2 = x.asrc ? x.imm : rt_val;
            m.sd = rt_val;
            m.v = x.v; m.we = x.v && x.we; m.mr = x.v && x.mr;
            m.ctrl = x.ctrl; m.rd = x.rd; m.dk = 1'b1;
        end
    endtask

    // Drive at the falling edge, sample stall before the rising edge, outputs just after.
    task automatic cycle(input in_t x);
        rst = x.rst;
        bus.id_valid_i = x.v; bus.id_rs_i = x.rs; bus.id_rt_i = x.rt;
        bus.id_rs_data_i = x.rsd; bus.id_rt_data_i = x.rtd; bus.id_imm_i = x.imm;
        bus.id_alu_src_i = x.asrc; bus.id_alu_ctrl_i = x.ctrl; bus.id_rd_i = x.rd;
        bus.id_wb_en_i = x.we; bus.id_mem_read_i = x.mr; bus.ex_result_i = x.exr;
        bus.wb_en_i = x.wben; bus.wb_rd_i = x.wbrd; bus.wb_data_i = x.wbd;
        bus.hold_i = x.hold; bus.flush_i = x.flush;
        #1;
        stall_act = bus.stall_o;
        model_step(x);
        @(posedge clk);
        #1;
        obs.v = bus.valid_o; obs.we = bus.wb_en_o; obs.mr = bus.mem_read_o;
        obs.ctrl = bus.ctrl_o; obs.rd = bus.rd_o; obs.s1 = bus.src1_o;
        obs.s2 = bus.src2_o; obs.sd = bus.store_data_o;
        @(negedge clk);
    endtask

    task automatic check_all(input string tag, input bit e_stall, input st_t e);
        chk({tag, ".stall"}, 64'(stall_act), 64'(e_stall));
        chk({tag, ".valid"}, 64'(obs.v), 64'(e.v));
        chk({tag, ".wb_en"}, 64'(obs.we), 64'(e.we));
        chk({tag, ".mem_read"}, 64'(obs.mr), 64'(e.mr));
        chk({tag, ".ctrl"}, 64'(obs.ctrl), 64'(e.ctrl));
        chk({tag, ".rd"}, 64'(obs.rd), 64'(e.rd));
        if (e.dk) begin
            chk({tag, ".src1"}, 64'(obs.s1), 64'(e.s1));
            chk({tag, ".src2"}, 64'(obs.s2), 64'(e.s2));
            chk({tag, ".store_data"}, 64'(obs.sd), 64'(e.sd));
        end
    endtask

    initial begin
        vec_t tbl[$];
        in_t  x;
        st_t  zero;
        st_t  held;
        string tag;

        zero = '{default: '0};
        zero.dk = 1'b1;
        m = '{default: '0};
        @(negedge clk);

        // Reset with random inputs
        for (int i = 0; i < 2; i++) begin
            x = rand_in();
            x.rst = 1; x.hold = 0;
            cycle(x);
            check_all($sformatf("reset%0d", i), 1'b0, zero);
        end

        // Directed vectors: fields after x are stall, valid, wb_en, mem_read, ctrl, rd,
        // src1, src2, store_data, data-defined.
        x = ins(1, 1, 2, 5, 7, 0, 0, 1, 3, 1, 0);
        tbl.push_back(vec(x, 0, 1, 1, 0, 1, 3, 5, 7, 7, 1));
        x = ins(1, 3, 1, 0, 5, 0, 0, 2, 4, 1, 0); x.exr = 32'h10;
        tbl.push_back(vec(x, 0, 1, 1, 0, 2, 4, 32'h10, 5, 5, 1));
        x = ins(1, 1, 2, 5, 7, 0, 0, 1, 3, 1, 0);
        tbl.push_back(vec(x, 0, 1, 1, 0, 1, 3, 5, 7, 7, 1));
        x = ins(1, 3, 1, 0, 5, 0, 0, 2, 4, 1, 0); x.exr = 32'h10;
        x.wben = 1; x.wbrd = 3; x.wbd = 32'h20;
        tbl.push_back(vec(x, 0, 1, 1, 0, 2, 4, 32'h10, 5, 5, 1));
        x = ins(1, 0, 0, 0, 0, 0, 0, 1, 8, 1, 0); x.exr = 32'hCAFE;
        x.wben = 1; x.wbrd = 0; x.wbd = 32'hFFFF_FFFF;
        tbl.push_back(vec(x, 0, 1, 1, 0, 1, 8, 0, 0, 0, 1));
        x = ins(1, 1, 0, 32'h100, 0, 4, 1, 3, 5, 1, 1);
        tbl.push_back(vec(x, 0, 1, 1, 1, 3, 5, 32'h100, 4, 0, 1));
        x = ins(1, 5, 7, 0, 32'h77, 0, 0, 1, 6, 1, 0);
        tbl.push_back(vec(x, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        x = ins(1, 5, 7, 0, 32'h77, 0, 0, 1, 6, 1, 0); x.wben = 1; x.wbrd = 5; x.wbd = 32'hAB;
        tbl.push_back(vec(x, 0, 1, 1, 0, 1, 6, 32'hAB, 32'h77, 32'h77, 1));
        x = ins(1, 1, 0, 32'h100, 0, 4, 1, 3, 5, 1, 1);
        tbl.push_back(vec(x, 0, 1, 1, 1, 3, 5, 32'h100, 4, 0, 1));
        x = ins(1, 7, 5, 32'h70, 32'h55, 3, 1, 1, 9, 1, 0);
        tbl.push_back(vec(x, 0, 1, 1, 0, 1, 9, 32'h70, 3, 32'h55, 1));
        x = ins(1, 0, 9, 0, 32'h11, 32'h1234, 1, 10, 10, 1, 0); x.exr = 32'hDEAD;
        tbl.push_back(vec(x, 0, 1, 1, 0, 10, 10, 0, 32'h1234, 32'hDEAD, 1));

        foreach (tbl[i]) begin
            cycle(tbl[i].x);
            check_all($sformatf("vec%0d", i), tbl[i].stall, tbl[i].e);
        end

        // Hold with flush pending: stage frozen, then flush lands as a bubble.
        held = tbl[tbl.size() - 1].e;
        for (int i = 0; i < 3; i++) begin
            x = rand_in();
            x.rst = 0; x.hold = 1; x.flush = 1;
            cycle(x);
            check_all($sformatf("hold%0d", i), 1'b1, held);
        end
        x = rand_in();
        x.rst = 0; x.hold = 0; x.flush = 1;
        cycle(x);
        held = '{default: '0};
        check_all("flush", 1'b0, held);

        // Reset while held drops the instruction but stall follows hold.
        x = ins(1, 1, 2, 3, 4, 0, 0, 5, 6, 1, 0);
        cycle(x);
        x.rst = 1; x.hold = 1;
        cycle(x);
        check_all("rst_hold", 1'b1, zero);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            x = rand_in();
            cycle(x);
            tag = $sformatf("rnd%0d", i);
            check_all(tag, m_stall, m);
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

ID/EX pipeline register that sits directly upstream of the ALU. It captures the decoded instruction, resolves RAW hazards by forwarding from the EX and MEM/WB stages, and selects the second operand between a register and the immediate. It detects load-use hazards and stalls decode while inserting a bubble. Its registered outputs drive the ALU's `src1_i`, `src2_i` and `ctrl_i` directly.

## Interface

**Parameters**
- `DW`, default 32: datapath width.
- `RW`, default 5: register index width.

**Ports**
- `clk_i`, input, 1: clock, rising edge.
- `rst_i`, input, 1: synchronous, active-high reset.
- `id_valid_i`, input, 1: the decode slot holds a real instruction.
- `id_rs_i`, input, RW: source register 1 index.
- `id_rt_i`, input, RW: source register 2 index.
- `id_rs_data_i`, input, DW: register-file value of rs.
- `id_rt_data_i`, input, DW: register-file value of rt.
- `id_imm_i`, input, DW: immediate, already extended.
- `id_alu_src_i`, input, 1: 1 selects `id_imm_i` as src2; rt is then unused.
- `id_alu_ctrl_i`, input, 4: ALU opcode.
- `id_rd_i`, input, RW: destination index.
- `id_wb_en_i`, input, 1: the instruction writes `id_rd_i`.
- `id_mem_read_i`, input, 1: the instruction is a load.
- `ex_result_i`, input, DW: ALU result of the instruction currently held in this stage.
- `wb_en_i`, input, 1: MEM/WB write enable.
- `wb_rd_i`, input, RW: MEM/WB destination index.
- `wb_data_i`, input, DW: MEM/WB write-back data.
- `hold_i`, input, 1: downstream busy; freeze this stage.
- `flush_i`, input, 1: squash the decode-slot instruction (taken branch).
- `stall_o`, output, 1: decode must hold its instruction this cycle (combinational).
- `valid_o`, output, 1: registered instruction valid.
- `src1_o`, output, DW: registered ALU operand 1.
- `src2_o`, output, DW: registered ALU operand 2.
- `ctrl_o`, output, 4: registered ALU opcode.
- `store_data_o`, output, DW: registered forwarded rt value, used as store data.
- `rd_o`, output, RW: registered destination index.
- `wb_en_o`, output, 1: registered write enable, gated by valid.
- `mem_read_o`, output, 1: registered load flag, gated by valid.

## Operation

**Forwarding** (computed combinationally, applied at capture). For each source index `s` (rs, and rt):
1. If `s == 0`, use the register-file value; index 0 is never forwarded.
2. Else if `valid_o & wb_en_o & ~mem_read_o & rd_o == s`, use `ex_result_i`.
3. Else if `wb_en_i & wb_rd_i == s`, use `wb_data_i`.
4. Otherwise use the register-file value.

EX has priority over MEM/WB.

**Operand select**
- `src2 = id_alu_src_i ? id_imm_i : fwd_rt`.
- `store_data = fwd_rt` in both cases.

**Load-use hazard**
- Condition: `valid_o & mem_read_o & rd_o != 0 & id_valid_i`, and `rd_o` equals `id_rs_i`, or `rd_o` equals `id_rt_i` with `id_alu_src_i == 0`.
- Response: assert `stall_o` and capture a bubble (`valid_o = 0`, all control outputs 0).
- Next cycle the load has left, so the condition clears and MEM/WB forwarding supplies the value.

**Per-cycle priority** (highest first):
1. `hold_i`: every register keeps its value; `stall_o = 1`.
2. `flush_i`: capture a bubble; `stall_o = 0`.
3. Load-use hazard: capture a bubble; `stall_o = 1`.
4. Normal: capture the decode slot; `valid_o = id_valid_i`; `stall_o = 0`.

**Bubble contents**
- Control outputs (`valid_o`, `wb_en_o`, `mem_read_o`, `ctrl_o`, `rd_o`) are 0.
- Data registers may hold any value.

## Timing

- Latency is 1 cycle: decode-slot values appear on the outputs after the next rising edge.
- `stall_o` is combinational from the current inputs and the registered state, so it is valid in the same cycle.
- **Reset:** when `rst_i` is sampled high, every output register goes to 0 (`valid_o`, `src1_o`, `src2_o`, `ctrl_o`, `store_data_o`, `rd_o`, `wb_en_o`, `mem_read_o`). Reset overrides `hold_i` and `flush_i`. A reset mid-stall drops the held instruction.
- `stall_o` is 0 during the reset cycle unless `hold_i` is high.
- When `hold_i` is high, `flush_i` is ignored. Upstream keeps `flush_i` asserted until the first cycle in which `hold_i` is low.
- Throughput is one instruction per cycle when there is no hazard. A load-use hazard costs exactly 1 bubble.

## Test plan

1. **Reset.** Assert `rst_i` for 2 cycles with random inputs -> all outputs 0 and `stall_o = 0` (with `hold_i = 0`).
2. **EX forward.** Issue `addu r3 = r1 + r2`, then `subu r4 = r3 - r1` with stale `rs_data = 0` for r3 and `ex_result_i = 0x0000_0010` -> the second instruction's `src1_o = 0x10`. Repeat with MEM/WB also writing r3 = 0x20 -> EX still wins, `src1_o = 0x10`.
3. **r0 guard.** With `wb_en_i = 1`, `wb_rd_i = 0`, `wb_data_i = 0xFFFF_FFFF`, issue an instruction reading r0 with `rs_data = 0` -> `src1_o = 0`.
4. **Load-use.** Load to r5, followed by `addu r6 = r5 + r7` -> `stall_o = 1` for 1 cycle and a bubble (`valid_o = 0`). Next cycle, with `wb_rd_i = 5`, `wb_data_i = 0xAB` -> `src1_o = 0xAB`, `valid_o = 1`. Repeat with an immediate form (`id_alu_src_i = 1`, rt = r5, rs = r7) -> no stall.
5. **Hold and flush.** Assert `hold_i` for 3 cycles while `flush_i = 1` -> outputs unchanged and `stall_o = 1` throughout. When `hold_i` drops, with `flush_i` still high -> bubble captured.
6. **Immediate select.** Issue `lui` with `id_alu_src_i = 1`, `imm = 0x0000_1234`, `ctrl = 10` -> `src2_o = 0x1234`, `ctrl_o = 10`, and `store_data_o` equals the forwarded rt value.
